// File: rtl/cmos_cfg_sched.sv
// -----------------------------------------------------------------------------
// cmos_cfg_sched
//   Schedules CMOS sensor register accesses onto the single CMOS SPI master.
//   Two requesters share the master: a boot-time init table held in an
//   external ROM, and the ESP32 host command path. Register writes are held
//   back until the sensor frame-overhead window is open; reads go out at once.
//   Host read data is returned on rsp_valid/rsp_data.
//
//   Command word (26 bits): {addr[25:17], rw[16], data[15:0]}, rw=1 is a write.
//   SPI frame (27 bits)   : {1'b0, command}.
//
// Optional feature (macro CMOS_CFG_READBACK_EN):
//   When defined, each init-table write is followed by a read of the same
//   address. The returned data is compared with the written data, and a
//   mismatch sets the sticky err_verify flag. Init continues either way.
//   When undefined, no readback frames are issued and err_verify stays 0.
//
// Ports
//   sys_clk, sys_rst_n       : clock, async active-low reset
//   init_start               : pulse, run the init table from entry 0
//   rom_addr / rom_data      : init ROM; data valid 1 cycle after the address
//   host_valid/ready/cmd     : host command handshake
//   fot_win                  : 1 = frame overhead time, writes allowed
//   spi_start/frame/busy/done/rdata : SPI serializer interface
//   rsp_valid / rsp_data     : host read response
//   init_done, busy, err_timeout, err_verify : status
// -----------------------------------------------------------------------------
module cmos_cfg_sched #(
    parameter int INIT_DEPTH  = 16,
    parameter int ROM_AW      = 4,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [25:0]       rom_data,
    input  logic              host_valid,
    input  logic [25:0]       host_cmd,
    output logic              host_ready,
    input  logic              fot_win,
    output logic              spi_start,
    output logic [26:0]       spi_frame,
    input  logic              spi_busy,
    input  logic              spi_done,
    input  logic [15:0]       spi_rdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic              init_done,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_verify
);

`ifdef CMOS_CFG_READBACK_EN
    localparam logic RB_EN = 1'b1;
`else
    localparam logic RB_EN = 1'b0;
`endif

    // Index needs one extra bit so it can reach INIT_DEPTH itself.
    localparam int IDX_W = ROM_AW + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ROMWAIT = 3'd2,
        S_DECODE  = 3'd3,
        S_WAITWIN = 3'd4,
        S_ISSUE   = 3'd5,
        S_RUN     = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx_r;
    logic [25:0]        cmd_r;
    logic               src_init_r;
    logic               rb_r;
    logic               init_pend_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [26:0]        frame_r;
    logic               rsp_valid_r;
    logic [15:0]        rsp_data_r;
    logic               init_done_r;
    logic               err_timeout_r;
    logic               err_verify_r;

    logic               spi_start_s;
    logic               host_ready_s;
    logic               host_acc_s;
    logic               init_go_s;
    logic [25:0]        dec_cmd_s;
    logic               end_mark_s;
    logic               tmo_hit_s;
    logic               tmo_warn_s;
    logic               rb_need_s;

    // A pending or fresh init request always beats the host in IDLE.
    assign init_go_s    = (state_r == S_IDLE) && (init_start || init_pend_r);
    assign host_ready_s = (state_r == S_IDLE) && init_done_r && !init_pend_r &&
                          !init_start && !spi_busy;
    assign host_acc_s   = host_valid && host_ready_s;
    assign dec_cmd_s    = src_init_r ? rom_data : cmd_r;
    assign end_mark_s   = src_init_r && ((rom_data[25:17] == 9'h1FF) ||
                                         (idx_r == IDX_W'(INIT_DEPTH)));
    assign tmo_hit_s    = (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
    // Flag raised one cycle ahead of the abort so busy drops the cycle after.
    assign tmo_warn_s   = (tmo_r == TMO_W'(TIMEOUT_CYC - 2));
    assign rb_need_s    = RB_EN && src_init_r && !rb_r && cmd_r[16];

    assign rom_addr    = idx_r[ROM_AW-1:0];
    assign host_ready  = host_ready_s;
    assign spi_start   = spi_start_s;
    assign spi_frame   = frame_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign init_done   = init_done_r;
    assign busy        = (state_r != S_IDLE);
    assign err_timeout = err_timeout_r;
    assign err_verify  = err_verify_r;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and the spi_start strobe.
    always_comb begin
        state_nx    = state_r;
        spi_start_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (init_go_s) begin
                    state_nx = S_FETCH;
                end else if (host_acc_s) begin
                    state_nx = S_DECODE;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_FETCH:   state_nx = S_ROMWAIT;
            S_ROMWAIT: state_nx = S_DECODE;
            S_DECODE: begin
                if (end_mark_s) begin
                    state_nx = S_IDLE;
                end else if (dec_cmd_s[16] && !fot_win) begin
                    state_nx = S_WAITWIN;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_WAITWIN: begin
                if (fot_win) begin
                    state_nx = S_ISSUE;
                end else begin
                    state_nx = S_WAITWIN;
                end
            end
            S_ISSUE: begin
                if (!spi_busy) begin
                    spi_start_s = 1'b1;
                    state_nx    = S_RUN;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_RUN: begin
                if (tmo_hit_s) begin
                    state_nx = S_IDLE;
                end else if (spi_done) begin
                    if (!src_init_r) begin
                        state_nx = S_IDLE;
                    end else if (rb_need_s) begin
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end else begin
                    state_nx = S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: command/frame capture, init index, timeout, response, flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_r         <= {IDX_W{1'b0}};
            cmd_r         <= 26'd0;
            src_init_r    <= 1'b0;
            rb_r          <= 1'b0;
            init_pend_r   <= 1'b0;
            tmo_r         <= {TMO_W{1'b0}};
            frame_r       <= 27'd0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 16'd0;
            init_done_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            err_verify_r  <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            // init_start is remembered only while a host command is in flight.
            if (init_start && (state_r != S_IDLE) && !src_init_r) begin
                init_pend_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (init_go_s) begin
                        src_init_r  <= 1'b1;
                        rb_r        <= 1'b0;
                        idx_r       <= {IDX_W{1'b0}};
                        init_pend_r <= 1'b0;
                    end else if (host_acc_s) begin
                        cmd_r      <= host_cmd;
                        src_init_r <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (end_mark_s) begin
                        init_done_r <= 1'b1;
                        idx_r       <= {IDX_W{1'b0}};
                        src_init_r  <= 1'b0;
                    end else begin
                        cmd_r   <= dec_cmd_s;
                        frame_r <= {1'b0, dec_cmd_s};
                    end
                end
                S_ISSUE: begin
                    if (!spi_busy) begin
                        tmo_r <= {TMO_W{1'b0}};
                    end
                end
                S_RUN: begin
                    if (tmo_hit_s) begin
                        // Abort; a later init_start restarts the table at 0.
                        src_init_r <= 1'b0;
                        rb_r       <= 1'b0;
                        idx_r      <= {IDX_W{1'b0}};
                    end else if (spi_done) begin
                        if (src_init_r) begin
                            if (rb_need_s) begin
                                rb_r    <= 1'b1;
                                frame_r <= {1'b0, cmd_r[25:17], 1'b0, 16'h0000};
                            end else begin
                                if (rb_r && (spi_rdata != cmd_r[15:0])) begin
                                    err_verify_r <= 1'b1;
                                end
                                rb_r  <= 1'b0;
                                idx_r <= idx_r + IDX_W'(1);
                            end
                        end else if (!cmd_r[16]) begin
                            rsp_data_r  <= spi_rdata;
                            rsp_valid_r <= 1'b1;
                        end
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                        if (tmo_warn_s) begin
                            err_timeout_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
